// File: rtl/key_debounce.sv
// Per-key synchroniser and debounce filter for active-low push-keys.
// It produces an active-high debounced level and one-clock press/release pulses.
module key_debounce #(
  parameter int KEY_NUM    = 4,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic               any_press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS_F = 2'd1,
    PRESSED = 2'd2,
    REL_F   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Released pins read as 1, so both flops reset to the released level.
  logic [KEY_NUM-1:0] r_s1;
  logic [KEY_NUM-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= key_in;
      r_s2 <= r_s1;
    end
  end

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_lvl;
    logic             w_lvl_nxt;
    logic             r_prs;
    logic             w_prs_nxt;
    logic             r_rel;
    logic             w_rel_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_lvl   <= 1'b0;
        r_prs   <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_lvl   <= w_lvl_nxt;
        r_prs   <= w_prs_nxt;
        r_rel   <= w_rel_nxt;
      end
    end

    // The filter states count consecutive samples of the new level; any sample
    // of the old level drops back and discards the partial count.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lvl_nxt   = r_lvl;
      w_prs_nxt   = 1'b0;
      w_rel_nxt   = 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_s2[k]) begin
            w_state_nxt = PRESS_F;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        PRESS_F: begin
          if (r_s2[k]) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
            w_lvl_nxt   = 1'b1;
            w_prs_nxt   = 1'b1;
          end else begin
            w_cnt_nxt   = sat_inc(r_cnt);
          end
        end
        PRESSED: begin
          if (r_s2[k]) begin
            w_state_nxt = REL_F;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        REL_F: begin
          if (!r_s2[k]) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_lvl_nxt   = 1'b0;
            w_rel_nxt   = 1'b1;
          end else begin
            w_cnt_nxt   = sat_inc(r_cnt);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_lvl_nxt   = 1'b0;
        end
      endcase
    end

    assign key_state[k]   = r_lvl;
    assign key_press[k]   = r_prs;
    assign key_release[k] = r_rel;
  end

  assign any_press = |key_press;

endmodule
